// File: rtl/ul_comp_pkg.sv
// ul_comp_pkg: widths, IQ types and helpers shared by the uplink compressor and decompressor
package ul_comp_pkg;
  localparam int MANT_W = 7;
  localparam int OUT_W = 16;
  localparam int RE_PER_PRB = 12;
  localparam int SHIFT_W = 4;
  localparam logic [SHIFT_W-1:0] MAX_SHIFT = SHIFT_W'(OUT_W - MANT_W);
  localparam logic [3:0] LAST_RE = 4'(RE_PER_PRB - 1);
  typedef struct packed {
    logic [MANT_W-1:0] i;
    logic [MANT_W-1:0] q;
  } cmp_iq_t;
  typedef struct packed {
    logic [OUT_W-1:0] i;
    logic [OUT_W-1:0] q;
  } iq_t;
  typedef struct packed {
    logic       vld;
    logic       sop;
    logic       eop;
    logic       frm;
    logic [6:0] slot;
    logic [3:0] symb;
    logic [8:0] prb;
    logic [3:0] re;
  } ctl_t;
  function automatic logic [OUT_W-1:0] sext(input logic [MANT_W-1:0] m);
    return {{(OUT_W - MANT_W){m[MANT_W-1]}}, m};
  endfunction
endpackage

// File: rtl/ul_decompress_lane.sv
// ul_decompress_lane: one antenna lane -- exponent latch/clamp, shift, 2-stage pipe.
// UL_DECOMP_ROUND_EN adds mid-point reconstruction (1<<(e-1)) for e > 0.
module ul_decompress_lane
  import ul_comp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 re0,
  input  logic [2*MANT_W-1:0]  i_data,
  input  logic [SHIFT_W-1:0]   i_shift,
  output logic [2*OUT_W-1:0]   o_data,
  output logic                 o_shift_err
);
  logic [SHIFT_W-1:0] shift_lat, e_sel, e_r;
  cmp_iq_t d_r;
  logic err_r;
  logic [OUT_W-1:0] rnd;
  assign e_sel = re0 ? i_shift : shift_lat;
`ifdef UL_DECOMP_ROUND_EN
  assign rnd = (OUT_W'(1) << e_r) >> 1;
`else
  assign rnd = '0;
`endif
  always_ff @(posedge clk)
    if (!rst) begin
      shift_lat   <= '0;
      d_r         <= '0;
      e_r         <= '0;
      err_r       <= 1'b0;
      o_data      <= '0;
      o_shift_err <= 1'b0;
    end else begin
      if (re0) shift_lat <= i_shift;
      d_r         <= i_data;
      e_r         <= (e_sel > MAX_SHIFT) ? MAX_SHIFT : e_sel;
      err_r       <= re0 && (i_shift > MAX_SHIFT);
      o_data      <= {(sext(d_r.i) << e_r) + rnd, (sext(d_r.q) << e_r) + rnd};
      o_shift_err <= err_r;
    end
endmodule

// File: rtl/ul_decompress_data.sv
// ul_decompress_data: 4-lane uplink BFP decompressor with PRB framing check and error count.
// Optional mid-point rounding is selected by UL_DECOMP_ROUND_EN inside the lanes.
module ul_decompress_data
  import ul_comp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_sop,
  input  logic        i_eop,
  input  logic        i_vld,
  input  logic [13:0] i_data_ant0,
  input  logic [13:0] i_data_ant1,
  input  logic [13:0] i_data_ant2,
  input  logic [13:0] i_data_ant3,
  input  logic [3:0]  i_shift0,
  input  logic [3:0]  i_shift1,
  input  logic [3:0]  i_shift2,
  input  logic [3:0]  i_shift3,
  input  logic [6:0]  i_slot_idx,
  input  logic [3:0]  i_symb_idx,
  input  logic [8:0]  i_prb_idx,
  output logic        o_sop,
  output logic        o_eop,
  output logic        o_vld,
  output logic [31:0] o_data_ant0,
  output logic [31:0] o_data_ant1,
  output logic [31:0] o_data_ant2,
  output logic [31:0] o_data_ant3,
  output logic [6:0]  o_slot_idx,
  output logic [3:0]  o_symb_idx,
  output logic [8:0]  o_prb_idx,
  output logic [3:0]  o_re_idx,
  output logic        o_frm_err,
  output logic        o_shift_err,
  output logic [15:0] o_err_cnt
);
  logic [3:0] re_cnt, re_idx;
  logic frm_err, re0;
  ctl_t m1, m2;
  logic [13:0] din [4];
  logic [3:0] sin [4];
  logic [31:0] dout [4];
  logic [3:0] serr;
  // sop restarts the PRB even when it arrives early; the sample is still RE 0
  assign re_idx  = (i_vld && i_sop) ? '0 : re_cnt;
  assign frm_err = i_vld && ((i_eop && re_idx != LAST_RE) || (i_sop && re_cnt != '0));
  assign re0     = i_vld && re_idx == '0;
  assign din = '{i_data_ant0, i_data_ant1, i_data_ant2, i_data_ant3};
  assign sin = '{i_shift0, i_shift1, i_shift2, i_shift3};
  for (genvar g = 0; g < 4; g++) begin : g_lane
    ul_decompress_lane u_lane (
      .clk        (clk),
      .rst        (rst),
      .re0        (re0),
      .i_data     (din[g]),
      .i_shift    (sin[g]),
      .o_data     (dout[g]),
      .o_shift_err(serr[g])
    );
  end
  always_ff @(posedge clk)
    if (!rst) begin
      re_cnt    <= '0;
      m1        <= '0;
      m2        <= '0;
      o_err_cnt <= '0;
    end else begin
      if (i_vld) re_cnt <= (i_eop || re_idx == LAST_RE) ? '0 : re_idx + 4'd1;
      m1 <= '{vld: i_vld, sop: i_vld && i_sop, eop: i_vld && i_eop, frm: frm_err,
              slot: i_slot_idx, symb: i_symb_idx, prb: i_prb_idx, re: re_idx};
      m2 <= m1;
      if ((o_frm_err || o_shift_err) && o_err_cnt != '1) o_err_cnt <= o_err_cnt + 16'd1;
    end
  assign o_vld       = m2.vld;
  assign o_sop       = m2.sop;
  assign o_eop       = m2.eop;
  assign o_frm_err   = m2.frm;
  assign o_slot_idx  = m2.slot;
  assign o_symb_idx  = m2.symb;
  assign o_prb_idx   = m2.prb;
  assign o_re_idx    = m2.re;
  assign o_shift_err = |serr;
  assign o_data_ant0 = dout[0];
  assign o_data_ant1 = dout[1];
  assign o_data_ant2 = dout[2];
  assign o_data_ant3 = dout[3];
endmodule

// File: tb/tb_ul_decompress_data.sv
// tb_ul_decompress_data: directed vectors with hand-computed expectations for ul_decompress_data
module tb_ul_decompress_data;
  logic clk = 1'b0, rst = 1'b0;
  logic i_sop = 1'b0, i_eop = 1'b0, i_vld = 1'b0;
  logic [13:0] i_data_ant0 = '0, i_data_ant1 = '0, i_data_ant2 = '0, i_data_ant3 = '0;
  logic [3:0] i_shift0 = '0, i_shift1 = '0, i_shift2 = '0, i_shift3 = '0;
  logic [6:0] i_slot_idx = '0;
  logic [3:0] i_symb_idx = '0;
  logic [8:0] i_prb_idx = '0;
  logic o_sop, o_eop, o_vld, o_frm_err, o_shift_err;
  logic [31:0] o_data_ant0, o_data_ant1, o_data_ant2, o_data_ant3;
  logic [6:0] o_slot_idx;
  logic [3:0] o_symb_idx, o_re_idx;
  logic [8:0] o_prb_idx;
  logic [15:0] o_err_cnt;
  int total = 0, bad = 0;
  bit cap_en = 1'b0;
  typedef struct {
    logic [31:0] d0, d1;
    logic [3:0]  re;
    logic        sop, eop, frm, serr;
    logic [8:0]  prb;
  } smp_t;
  smp_t cap[$];
`ifdef UL_DECOMP_ROUND_EN
  localparam logic [31:0] E1 = 32'h01F8FFF8, E1B = 32'h000C000C, E2 = 32'h81007F00,
                          E3 = 32'h00060006, E6 = 32'h00030003;
`else
  localparam logic [31:0] E1 = 32'h01F0FFF0, E1B = 32'h00080008, E2 = 32'h80007E00,
                          E3 = 32'h00040004, E6 = 32'h00020002;
`endif
  ul_decompress_data dut (
    .clk(clk), .rst(rst), .i_sop(i_sop), .i_eop(i_eop), .i_vld(i_vld),
    .i_data_ant0(i_data_ant0), .i_data_ant1(i_data_ant1),
    .i_data_ant2(i_data_ant2), .i_data_ant3(i_data_ant3),
    .i_shift0(i_shift0), .i_shift1(i_shift1), .i_shift2(i_shift2), .i_shift3(i_shift3),
    .i_slot_idx(i_slot_idx), .i_symb_idx(i_symb_idx), .i_prb_idx(i_prb_idx),
    .o_sop(o_sop), .o_eop(o_eop), .o_vld(o_vld),
    .o_data_ant0(o_data_ant0), .o_data_ant1(o_data_ant1),
    .o_data_ant2(o_data_ant2), .o_data_ant3(o_data_ant3),
    .o_slot_idx(o_slot_idx), .o_symb_idx(o_symb_idx), .o_prb_idx(o_prb_idx),
    .o_re_idx(o_re_idx), .o_frm_err(o_frm_err), .o_shift_err(o_shift_err),
    .o_err_cnt(o_err_cnt)
  );
  always #5 clk = ~clk;
  always begin
    @(posedge clk);
    #1;
    if (cap_en && o_vld)
      cap.push_back('{d0: o_data_ant0, d1: o_data_ant1, re: o_re_idx, sop: o_sop,
                      eop: o_eop, frm: o_frm_err, serr: o_shift_err, prb: o_prb_idx});
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drv(input logic v, input logic s, input logic e,
                     input logic [13:0] d, input logic [3:0] sh);
    i_vld = v;
    i_sop = s;
    i_eop = e;
    i_data_ant0 = d;
    i_shift0 = sh;
    @(posedge clk);
    #1;
  endtask
  task automatic flush();
    repeat (3) drv(1'b0, 1'b0, 1'b0, 14'h0, 4'h0);
  endtask
  task automatic chk_prb(input string tag, input int n, input logic [31:0] e0);
    chk({tag, "_n"}, cap.size(), n);
    for (int k = 0; k < cap.size(); k++) begin
      chk($sformatf("%s_d%0d", tag, k), cap[k].d0, e0);
      chk($sformatf("%s_re%0d", tag, k), {28'h0, cap[k].re}, k);
      chk($sformatf("%s_frm%0d", tag, k), {31'h0, cap[k].frm}, 0);
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", {31'h0, o_vld}, 0);
    chk("rst_d0", o_data_ant0, 0);
    chk("rst_cnt", {16'h0, o_err_cnt}, 0);
    rst = 1'b1;
    cap_en = 1'b1;
    // full PRB, exponent 4, lane 1 with exponent 3
    i_slot_idx = 7'd5; i_symb_idx = 4'd3; i_prb_idx = 9'd100;
    i_data_ant1 = 14'h0081; i_shift1 = 4'd3;
    drv(1'b1, 1'b1, 1'b0, 14'h0FFF, 4'd4);
    chk("lat_early", {31'h0, o_vld}, 0);
    drv(1'b1, 1'b0, 1'b0, 14'h0FFF, 4'd4);
    chk("lat_vld", {31'h0, o_vld}, 1);
    chk("lat_sop", {31'h0, o_sop}, 1);
    chk("lat_slot", {25'h0, o_slot_idx}, 5);
    for (int k = 2; k < 12; k++) drv(1'b1, 1'b0, k == 11, 14'h0FFF, 4'd4);
    flush();
    chk_prb("p1", 12, E1);
    if (cap.size() == 12) begin
      chk("p1_d1", cap[0].d1, E1B);
      chk("p1_prb", {23'h0, cap[0].prb}, 100);
      chk("p1_eop", {31'h0, cap[11].eop}, 1);
      chk("p1_serr", {31'h0, cap[0].serr}, 0);
    end
    chk("p1_cnt", {16'h0, o_err_cnt}, 0);
    cap.delete();
    // exponent 12 clamps to 9
    for (int k = 0; k < 12; k++) drv(1'b1, k == 0, k == 11, 14'h203F, 4'd12);
    flush();
    chk_prb("p2", 12, E2);
    if (cap.size() == 12) begin
      chk("p2_serr0", {31'h0, cap[0].serr}, 1);
      chk("p2_serr1", {31'h0, cap[1].serr}, 0);
      chk("p2_serr11", {31'h0, cap[11].serr}, 0);
    end
    chk("p2_cnt", {16'h0, o_err_cnt}, 1);
    cap.delete();
    // mid-PRB exponent change is ignored
    for (int k = 0; k < 12; k++) drv(1'b1, k == 0, k == 11, 14'h0081, k < 5 ? 4'd2 : 4'd7);
    flush();
    chk_prb("p3", 12, E3);
    cap.delete();
    // eop on RE 7, then a PRB started by the counter alone
    for (int k = 0; k < 8; k++) drv(1'b1, k == 0, k == 7, 14'h0081, 4'd0);
    for (int k = 0; k < 12; k++) drv(1'b1, 1'b0, k == 11, 14'h0081, 4'd0);
    flush();
    chk("p4_n", cap.size(), 20);
    if (cap.size() == 20) begin
      chk("p4_frm6", {31'h0, cap[6].frm}, 0);
      chk("p4_frm7", {31'h0, cap[7].frm}, 1);
      chk("p4_re7", {28'h0, cap[7].re}, 7);
      chk("p4_re8", {28'h0, cap[8].re}, 0);
      chk("p4_frm8", {31'h0, cap[8].frm}, 0);
      chk("p4_d8", cap[8].d0, 32'h00010001);
      chk("p4_re19", {28'h0, cap[19].re}, 11);
      chk("p4_frm19", {31'h0, cap[19].frm}, 0);
    end
    chk("p4_cnt", {16'h0, o_err_cnt}, 2);
    cap.delete();
    // early sop at RE 3
    for (int k = 0; k < 15; k++) drv(1'b1, k == 0 || k == 3, k == 14, 14'h0081, 4'd0);
    flush();
    chk("p5_n", cap.size(), 15);
    if (cap.size() == 15) begin
      chk("p5_frm3", {31'h0, cap[3].frm}, 1);
      chk("p5_re3", {28'h0, cap[3].re}, 0);
      chk("p5_frm2", {31'h0, cap[2].frm}, 0);
      chk("p5_re14", {28'h0, cap[14].re}, 11);
      chk("p5_frm14", {31'h0, cap[14].frm}, 0);
    end
    chk("p5_cnt", {16'h0, o_err_cnt}, 3);
    cap.delete();
    // valid gaps inside a PRB
    for (int k = 0; k < 12; k++) begin
      drv(1'b1, k == 0, k == 11, 14'h0081, 4'd1);
      if (k % 3 != 2) drv(1'b0, 1'b0, 1'b0, 14'h3FFF, 4'd15);
    end
    flush();
    chk_prb("p6", 12, E6);
    cap.delete();
    // counter saturation
    cap_en = 1'b0;
    for (int k = 0; k < 70000; k++) drv(1'b1, 1'b0, 1'b1, 14'h0, 4'd0);
    chk("sat_frm", {31'h0, o_frm_err}, 1);
    flush();
    chk("sat_cnt", {16'h0, o_err_cnt}, 32'hFFFF);
    // reset in the middle of a PRB
    for (int k = 0; k < 5; k++) drv(1'b1, k == 0, 1'b0, 14'h0FFF, 4'd4);
    chk("pre_rst_vld", {31'h0, o_vld}, 1);
    rst = 1'b0;
    drv(1'b1, 1'b0, 1'b0, 14'h0FFF, 4'd4);
    chk("mrst_vld", {31'h0, o_vld}, 0);
    chk("mrst_d0", o_data_ant0, 0);
    chk("mrst_re", {28'h0, o_re_idx}, 0);
    chk("mrst_prb", {23'h0, o_prb_idx}, 0);
    chk("mrst_cnt", {16'h0, o_err_cnt}, 0);
    rst = 1'b1;
    cap_en = 1'b1;
    for (int k = 0; k < 12; k++) drv(1'b1, 1'b0, k == 11, 14'h0FFF, 4'd4);
    flush();
    chk_prb("p8", 12, E1);
    chk("p8_cnt", {16'h0, o_err_cnt}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ul_decompress_data.md
# ul_decompress_data

Uplink block-floating-point decompressor: the receive-side counterpart of the 4-antenna PRB compressor. Takes four lanes of 14-bit compressed IQ (7-bit I, 7-bit Q) plus a 4-bit per-PRB exponent per lane, and reconstructs 16+16-bit IQ. Checks PRB framing (12 REs per PRB), carries slot/symbol/PRB metadata with matched latency, and counts framing and exponent errors. Sits between the fronthaul unpacker and the PUSCH dimension-reduction datapath.

## Interface
- MANT_W, 7: mantissa width per I or Q.
- OUT_W, 16: reconstructed width per I or Q.
- RE_PER_PRB, 12: REs per PRB.
- MAX_SHIFT, 9: largest legal exponent (OUT_W-MANT_W).
- clk  in  1  sole clock.
- rst  in  1  reset, synchronous, active-low.
- i_sop / i_eop / i_vld  in  1 each  framing, shared by all lanes; sop/eop qualified by i_vld.
- i_data_ant0..3  in  14 each  {I[13:7], Q[6:0]}, two's complement.
- i_shift0..3  in  4 each  per-lane exponent; sampled only on RE 0 of each PRB.
- i_slot_idx / i_symb_idx / i_prb_idx  in  7 / 4 / 9  metadata.
- o_sop / o_eop / o_vld  out  1 each  delayed framing.
- o_data_ant0..3  out  32 each  {I[31:16], Q[15:0]}.
- o_slot_idx / o_symb_idx / o_prb_idx  out  7 / 4 / 9  delayed metadata.
- o_re_idx  out  4  RE index (0..11) of the output sample.
- o_frm_err  out  1  one-cycle pulse, framing error.
- o_shift_err  out  1  one-cycle pulse, exponent > MAX_SHIFT on any lane.
- o_err_cnt  out  16  saturating count of cycles with o_frm_err or o_shift_err.

## Operation
- RE counter re_cnt (0..11): on i_vld, i_sop forces this sample to RE 0; otherwise the sample takes re_cnt. re_cnt advances after each valid sample, wraps 11→0. Invalid cycles hold it.
- Exponent latch per lane: on a valid sample at RE 0 the lane uses i_shiftN and stores it; REs 1..11 use the stored value. Changes on i_shiftN mid-PRB are ignored.
- Clamp: a latched exponent > MAX_SHIFT is replaced by MAX_SHIFT; o_shift_err pulses on the RE-0 sample (not repeated for REs 1..11).
- Reconstruction per I and Q: sign-extend 7→16, arithmetic shift left by exponent. Max magnitude 63<<9 (+rounding) < 2^15; no saturation logic needed.
- Framing error: valid eop on a sample whose RE index ≠ 11 → o_frm_err pulses with that sample; re_cnt returns to 0. Valid sop on a sample where re_cnt ≠ 0 → o_frm_err; sample is still treated as RE 0. Both on one sample → single pulse.
- Data is never dropped; erroneous samples are output and flagged.
- o_err_cnt increments by 1 per flagged cycle, saturates at 16'hFFFF, cleared only by reset.

## Timing
- Fixed latency 2 cycles input→output for data, framing, metadata, o_re_idx, o_frm_err, o_shift_err. Stage 1: RE index, exponent select/clamp, input register. Stage 2: shift/round, output register.
- No backpressure; accepts one sample per cycle, full throughput.
- o_err_cnt updates one cycle after the flag appears on the output.
- Reset: every output 0; re_cnt, exponent latches, pipeline, error counter cleared. Reset mid-PRB discards the PRB; the next PRB requires a fresh RE 0 (sop, or counter at 0).

## Configuration
- UL_DECOMP_ROUND_EN defined: for exponent e > 0, add 1<<(e-1) after shifting (mid-point reconstruction), both signs. Exponent 0 unchanged.
- Undefined: zero-fill low bits, no offset. Latency identical both ways.

## Structure
- Package ul_comp_pkg: MANT_W, OUT_W, RE_PER_PRB, MAX_SHIFT; packed struct cmp_iq_t {i, q} (7+7) and iq_t {i, q} (16+16); shared with the compressor.
- Sub-module ul_decompress_lane: one lane (exponent latch, clamp, shift/round, 2-stage pipe); instantiated 4×. RE counter, framing check, metadata delay, error counter live in the top.

## Test plan
- sop, shift0=4, data0=0x0FFF for RE 0..11, eop on RE 11 → o_data_ant0=0x01F0FFF0 ×12, 2 cycles later; o_re_idx 0..11; no errors. With UL_DECOMP_ROUND_EN: 0x01F8FFF8.
- shift0=12 at RE 0, data0=0x203F → o_data_ant0=0x8000_7E00, o_shift_err one pulse, o_err_cnt=1.
- shift0=2 at RE 0, then shift0=7 on RE 5 → all 12 REs use exponent 2.
- eop on RE 7 → o_frm_err on that sample; next valid sample emerges with o_re_idx=0.
- i_vld gaps inside a PRB → re_cnt holds; 12 valid outputs, indices contiguous 0..11.
- Drive 70000 consecutive eop-on-RE-0 errors → o_err_cnt sticks at 0xFFFF; assert rst low mid-PRB → all outputs 0 next cycle.
